// File: rtl/ifetch_unit_pkg.sv
// ifetch_defs: shared definitions for the fetch stage.
//   if_state_e    - fetch FSM state encoding (idle / requesting / draining)
//   QueueDepth    - entries in the fetch-to-decode buffer
//   DefaultPcStep - default fetch-address increment per accepted word
package ifetch_defs;

  typedef enum logic [1:0] {
    IfIdle  = 2'd0,
    IfReq   = 2'd1,
    IfDrain = 2'd2
  } if_state_e;

  localparam int unsigned QueueDepth    = 2;
  localparam int unsigned DefaultPcStep = 4;

endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: 2-entry {pc, data} FIFO between instruction memory and decode.
// Head entry always sits in slot 0 so the head outputs come straight from registers.
//   clk_i, rst_i       - clock, synchronous active-high reset
//   flush_i            - empty the queue (wins over push/pop)
//   push_i             - write {push_pc_i, push_data_i} at the tail
//   pop_i              - drop the head entry
//   count_o            - occupancy, 0..2
//   head_valid_o       - queue not empty
//   head_pc_o/_data_o  - head entry
module ifetch_queue
  import ifetch_defs::*;
#(
  parameter int unsigned WordW = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WordW-1:0] push_pc_i,
  input  logic [WordW-1:0] push_data_i,
  output logic [1:0]       count_o,
  output logic             head_valid_o,
  output logic [WordW-1:0] head_pc_o,
  output logic [WordW-1:0] head_data_o
);

  logic [WordW-1:0] pc_q   [QueueDepth];
  logic [WordW-1:0] data_q [QueueDepth];
  logic [1:0]       count_q;
  logic             pop_en;
  logic             push_en;

  assign pop_en  = pop_i & (count_q != 2'd0);
  // A push into a full queue is only accepted alongside a pop.
  assign push_en = push_i & ((count_q != 2'(QueueDepth)) | pop_en);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      pc_q[0]   <= '0;
      pc_q[1]   <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else begin
      case ({push_en, pop_en})
        2'b10: begin
          pc_q[count_q[0]]   <= push_pc_i;
          data_q[count_q[0]] <= push_data_i;
          count_q            <= count_q + 2'd1;
        end
        2'b01: begin
          pc_q[0]   <= pc_q[1];
          data_q[0] <= data_q[1];
          count_q   <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            pc_q[0]   <= push_pc_i;
            data_q[0] <= push_data_i;
          end else begin
            pc_q[0]   <= pc_q[1];
            data_q[0] <= data_q[1];
            pc_q[1]   <= push_pc_i;
            data_q[1] <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != 2'd0);
  assign head_pc_o    = pc_q[0];
  assign head_data_o  = data_q[0];

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage. Owns the fetch address, issues single-word reads to
// instruction memory, buffers returned words and hands them to decode.
//   clk_i, rst_i              - clock, synchronous active-high reset
//   redirect_valid_i/_pc_i    - load a new fetch address and flush everything
//   mem_req_o, mem_addr_o     - read request; address stable while mem_req_o=1
//   mem_ack_i, mem_rdata_i    - one-cycle response strobe with data
//   ins_valid_o/_ready_i      - decode handshake; ins_data_o/ins_pc_o head entry
// Optional (macro IFETCH_PERF_EN):
//   fetch_count_o             - pushed instructions (wraps)
//   stall_count_o             - cycles with ins_valid_o=0 while not idle
module ifetch_unit
  import ifetch_defs::*;
#(
  parameter int unsigned      WordW   = 32,
  parameter int unsigned      PcStep  = DefaultPcStep,
  parameter logic [WordW-1:0] ResetPc = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             redirect_valid_i,
  input  logic [WordW-1:0] redirect_pc_i,
  output logic             mem_req_o,
  output logic [WordW-1:0] mem_addr_o,
  input  logic             mem_ack_i,
  input  logic [WordW-1:0] mem_rdata_i,
  output logic             ins_valid_o,
  input  logic             ins_ready_i,
  output logic [WordW-1:0] ins_data_o,
  output logic [WordW-1:0] ins_pc_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]      fetch_count_o,
  output logic [31:0]      stall_count_o
`endif
);

  if_state_e        state_q, state_d;
  logic [WordW-1:0] fetch_pc_q, fetch_pc_d;
  logic [WordW-1:0] mem_addr_q;
  logic             mem_req_q;
  logic [1:0]       q_count;
  logic             ack, pop, push;
  logic [2:0]       occ_next;
  logic             credit;

  // Acks without an outstanding request are ignored.
  assign ack  = mem_ack_i & mem_req_q;
  assign pop  = ins_valid_o & ins_ready_i;
  assign push = (state_q == IfReq) & ack & ~redirect_valid_i;

  // Occupancy after this cycle; a new request may go out only if it stays below depth.
  assign occ_next = {1'b0, q_count} - {2'b0, pop} + {2'b0, push};
  assign credit   = (occ_next < 3'(QueueDepth));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IfIdle: begin
        if (redirect_valid_i || credit) state_d = IfReq;
      end
      IfReq: begin
        if (redirect_valid_i) state_d = ack ? IfReq : IfDrain;
        else if (ack)         state_d = credit ? IfReq : IfIdle;
      end
      IfDrain: begin
        if (ack) state_d = (redirect_valid_i || credit) ? IfReq : IfIdle;
      end
      default: state_d = IfIdle;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid_i) fetch_pc_d = redirect_pc_i;
    else if (push)        fetch_pc_d = fetch_pc_q + WordW'(PcStep);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IfIdle;
      fetch_pc_q <= ResetPc;
      mem_req_q  <= 1'b0;
      mem_addr_q <= ResetPc;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= (state_d != IfIdle);
      // While draining, the abandoned request keeps its original address.
      mem_addr_q <= (state_d == IfDrain) ? mem_addr_q : fetch_pc_d;
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

  ifetch_queue #(
    .WordW(WordW)
  ) u_queue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (redirect_valid_i),
    .push_i       (push),
    .pop_i        (pop),
    .push_pc_i    (fetch_pc_q),
    .push_data_i  (mem_rdata_i),
    .count_o      (q_count),
    .head_valid_o (ins_valid_o),
    .head_pc_o    (ins_pc_o),
    .head_data_o  (ins_data_o)
  );

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (push) fetch_count_q <= fetch_count_q + 32'd1;
      if (!ins_valid_o && (state_q != IfIdle)) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count_o = fetch_count_q;
  assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  localparam logic [31:0] Key = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .mem_req_o        (mem_req),
    .mem_addr_o       (mem_addr),
    .mem_ack_i        (mem_ack),
    .mem_rdata_i      (mem_rdata),
    .ins_valid_o      (ins_valid),
    .ins_ready_i      (ins_ready),
    .ins_data_o       (ins_data),
    .ins_pc_o         (ins_pc)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_count_o    (fetch_count),
    .stall_count_o    (stall_count)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory data is a fixed function of the address; outputs sampled on negedge.
  task automatic step();
    mem_rdata = mem_addr ^ Key;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ins_ready = 1'b0; mem_ack = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step();
    step();
  endtask

  typedef struct {
    logic        rdy;
    logic        ack;
    logic        req_e;
    logic [31:0] addr_e;
    logic        vld_e;
    logic [31:0] pc_e;
  } vec_t;

  vec_t tbl [13];

  // Random-phase model state
  logic [31:0] exp_pc;
  logic [31:0] pend_addr;
  logic        pend;
  int          wait_cnt;
  int          lat;
  int          pops;
  logic        rnd_rst;

  initial begin
    // Streaming from reset, then back-pressure and resume (explicit acks).
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'd4,  1'b1, 32'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd4};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd8};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd12};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'd20, 1'b1, 32'd12};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'd20, 1'b1, 32'd12};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'd20, 1'b1, 32'd16};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'd20, 1'b1, 32'd16};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'd24, 1'b1, 32'd16};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'd24, 1'b1, 32'd20};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 32'd24, 1'b0, 32'd0};

    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    do_reset();
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_valid", {31'd0, ins_valid}, 32'd0);
    check("rst_data", ins_data, 32'd0);
    check("rst_pc", ins_pc, 32'd0);
`ifdef IFETCH_PERF_EN
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_stall_count", stall_count, 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      check($sformatf("tbl%0d_req", i), {31'd0, mem_req}, {31'd0, tbl[i].req_e});
      check($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr_e);
      check($sformatf("tbl%0d_valid", i), {31'd0, ins_valid}, {31'd0, tbl[i].vld_e});
      if (tbl[i].vld_e) begin
        check($sformatf("tbl%0d_pc", i), ins_pc, tbl[i].pc_e);
        check($sformatf("tbl%0d_data", i), ins_data, tbl[i].pc_e ^ Key);
      end
      ins_ready = tbl[i].rdy;
      mem_ack   = tbl[i].ack;
      step();
    end
`ifdef IFETCH_PERF_EN
    check("tbl_fetch_count", fetch_count, 32'd6);
    check("tbl_stall_count", stall_count, 32'd2);
`endif

    // Decode stalled: exactly two words accepted, then fetch resumes at 8.
    do_reset(); rst = 1'b0;
    step();
    check("bp_req0", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; step();
    check("bp_addr1", mem_addr, 32'd4);
    step();
    check("bp_full_req", {31'd0, mem_req}, 32'd0);
    check("bp_head_pc", ins_pc, 32'd0);
    mem_ack = 1'b0; step();
    check("bp_hold_req", {31'd0, mem_req}, 32'd0);
    ins_ready = 1'b1; step();
    check("bp_resume_req", {31'd0, mem_req}, 32'd1);
    check("bp_resume_addr", mem_addr, 32'd8);
    check("bp_next_pc", ins_pc, 32'd4);
`ifdef IFETCH_PERF_EN
    check("bp_fetch_count", fetch_count, 32'd2);
`endif
    // Reset mid-operation with two words queued; a stray ack afterwards is ignored.
    ins_ready = 1'b0; mem_ack = 1'b1; step();
    mem_ack = 1'b0; rst = 1'b1; step();
    check("midrst_valid", {31'd0, ins_valid}, 32'd0);
    check("midrst_req", {31'd0, mem_req}, 32'd0);
    check("midrst_addr", mem_addr, 32'd0);
`ifdef IFETCH_PERF_EN
    check("midrst_fetch_count", fetch_count, 32'd0);
`endif
    rst = 1'b0; mem_ack = 1'b1; step();
    check("stray_req", {31'd0, mem_req}, 32'd1);
    check("stray_addr", mem_addr, 32'd0);
    mem_ack = 1'b0; step();
    check("stray_valid", {31'd0, ins_valid}, 32'd0);

    // Redirect while the request to 0x8 waits for its ack.
    do_reset(); rst = 1'b0; ins_ready = 1'b1;
    step();
    mem_ack = 1'b1; step();
    step();
    check("rd_wait_addr", mem_addr, 32'd8);
    mem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100; step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drain%0d_req", k), {31'd0, mem_req}, 32'd1);
      check($sformatf("drain%0d_addr", k), mem_addr, 32'd8);
      check($sformatf("drain%0d_valid", k), {31'd0, ins_valid}, 32'd0);
      mem_ack = (k == 2);
      step();
    end
    check("rd_tgt_addr", mem_addr, 32'h100);
    check("rd_tgt_valid", {31'd0, ins_valid}, 32'd0);
    mem_ack = 1'b1; step();
    check("rd_first_valid", {31'd0, ins_valid}, 32'd1);
    check("rd_first_pc", ins_pc, 32'h100);
    check("rd_first_data", ins_data, 32'h100 ^ Key);

    // Redirect with ack and pop in the same cycle.
    redirect_valid = 1'b1; redirect_pc = 32'h200; step();
    check("rap_valid", {31'd0, ins_valid}, 32'd0);
    check("rap_req", {31'd0, mem_req}, 32'd1);
    check("rap_addr", mem_addr, 32'h200);

    // Address wraps past the top of the address space.
    redirect_pc = 32'hFFFF_FFFC; step();
    check("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0; ins_ready = 1'b0; step();
    check("wrap_addr1", mem_addr, 32'h0000_0000);
    check("wrap_pc", ins_pc, 32'hFFFF_FFFC);

    // Randomized traffic against an instruction-stream model.
    mem_ack = 1'b0; redirect_valid = 1'b0;
    do_reset(); rst = 1'b0;
    exp_pc = 32'd0; pend = 1'b0; wait_cnt = 0; lat = $urandom_range(0, 3); pops = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pend && mem_req) check("addr_stable", mem_addr, pend_addr);
      rnd_rst        = ($urandom_range(0, 399) == 0);
      rst            = rnd_rst;
      ins_ready      = !rnd_rst && ($urandom_range(0, 9) < 7);
      redirect_valid = !rnd_rst && ($urandom_range(0, 29) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      if (mem_req) begin
        if (wait_cnt >= lat) begin
          mem_ack = 1'b1; wait_cnt = 0; lat = $urandom_range(0, 3); pend = 1'b0;
        end else begin
          mem_ack = 1'b0; wait_cnt++; pend = 1'b1; pend_addr = mem_addr;
        end
      end else begin
        mem_ack = 1'b0; wait_cnt = 0; pend = 1'b0;
      end
      if (ins_valid && ins_ready) begin
        check("stream_pc", ins_pc, exp_pc);
        check("stream_data", ins_data, exp_pc ^ Key);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      if (rnd_rst) exp_pc = 32'd0;
      step();
    end
    rst = 1'b0; mem_ack = 1'b0; redirect_valid = 1'b0;
    check("stream_progress", {31'd0, pops >= 300}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
